// File: rtl/car_sprite_pkg.sv
// Shared constants and state encoding for the car sprite draw/erase engine.
package car_sprite_pkg;

  localparam int DEF_SCR_W = 160;
  localparam int DEF_SCR_H = 120;
  localparam int BG_AW     = 15;
  localparam logic [2:0] DEF_TRANSP = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DRAW        = 3'd1,
    ST_DRAW_FLUSH  = 3'd2,
    ST_DRAW_DONE   = 3'd3,
    ST_ERASE       = 3'd4,
    ST_ERASE_FLUSH = 3'd5,
    ST_ERASE_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// Raster row/col counter over a CAR_W x CAR_H box; o_last marks the final pixel.
module sprite_scan_counter #(
  parameter int CAR_W = 8,
  parameter int CAR_H = 8,
  localparam int CW = (CAR_W > 1) ? $clog2(CAR_W) : 1,
  localparam int RW = (CAR_H > 1) ? $clog2(CAR_H) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last
);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_col_wrap;
  logic          w_row_wrap;

  assign w_col_wrap = (r_col == CW'(CAR_W - 1));
  assign w_row_wrap = (r_row == RW'(CAR_H - 1));

  always_ff @(posedge clk) begin
    if (!resetn || i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = w_col_wrap && w_row_wrap;

endmodule

// File: rtl/car_sprite_engine.sv
// Sweeps the car box to the VGA pixel port from the sprite ROM (draw) or the
// background ROM (erase), answering the animation FSM with level done flags.
module car_sprite_engine
  import car_sprite_pkg::*;
#(
  parameter int CAR_W    = 8,
  parameter int CAR_H    = 8,
  parameter int SCR_W    = DEF_SCR_W,
  parameter int SCR_H    = DEF_SCR_H,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] TRANSP = DEF_TRANSP
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              ldXY,
  input  logic [X_W-1:0]                    car_x,
  input  logic [Y_W-1:0]                    car_y,
  input  logic                              drawCarEnable,
  input  logic                              eraseCarEnable,
  output logic [$clog2(CAR_W*CAR_H)-1:0]    spr_addr,
  input  logic [COLOUR_W-1:0]               spr_data,
  output logic [BG_AW-1:0]                  bg_addr,
  input  logic [COLOUR_W-1:0]               bg_data,
  output logic [X_W-1:0]                    vga_x,
  output logic [Y_W-1:0]                    vga_y,
  output logic [COLOUR_W-1:0]               vga_colour,
  output logic                              plot,
  output logic                              drawCarDone,
  output logic                              eraseCarDone,
  output state_t                            o_dbg_state
);

  localparam int CW     = (CAR_W > 1) ? $clog2(CAR_W) : 1;
  localparam int RW     = (CAR_H > 1) ? $clog2(CAR_H) : 1;
  localparam int SPR_AW = $clog2(CAR_W * CAR_H);

  state_t        r_state;
  logic [X_W-1:0] r_x0;
  logic [Y_W-1:0] r_y0;
  logic          r_valid_d;
  logic          r_erase_d;
  logic [CW-1:0] r_col_d;
  logic [RW-1:0] r_row_d;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_last;
  logic          w_issue;
  logic          w_clr;
  logic [X_W:0]  w_xs_a;
  logic [Y_W:0]  w_ys_a;
  logic [X_W:0]  w_xs_d;
  logic [Y_W:0]  w_ys_d;
  logic          w_onscreen;
  logic [COLOUR_W-1:0] w_pix;

  // An address is issued only while the matching enable is still held, so an
  // abort stops the counter and clears the pipeline on the same edge.
  assign w_issue = ((r_state == ST_DRAW)  && drawCarEnable) ||
                   ((r_state == ST_ERASE) && eraseCarEnable);
  assign w_clr   = !w_issue;

  sprite_scan_counter #(
    .CAR_W (CAR_W),
    .CAR_H (CAR_H)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (w_issue),
    .i_clr  (w_clr),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_last (w_last)
  );

  assign w_xs_a   = {1'b0, r_x0} + (X_W+1)'(w_col);
  assign w_ys_a   = {1'b0, r_y0} + (Y_W+1)'(w_row);
  assign spr_addr = SPR_AW'(w_row) * SPR_AW'(CAR_W) + SPR_AW'(w_col);
  assign bg_addr  = BG_AW'(w_ys_a) * BG_AW'(SCR_W) + BG_AW'(w_xs_a);

  // ROM data lags the address by one cycle, so the pixel stage uses the
  // delayed counters; the extra sum bit catches right/bottom overhang.
  assign w_xs_d     = {1'b0, r_x0} + (X_W+1)'(r_col_d);
  assign w_ys_d     = {1'b0, r_y0} + (Y_W+1)'(r_row_d);
  assign w_onscreen = (w_xs_d < (X_W+1)'(SCR_W)) && (w_ys_d < (Y_W+1)'(SCR_H));
  assign w_pix      = r_erase_d ? bg_data : spr_data;

  assign vga_x        = w_xs_d[X_W-1:0];
  assign vga_y        = w_ys_d[Y_W-1:0];
  assign vga_colour   = r_valid_d ? w_pix : '0;
  assign plot         = r_valid_d && w_onscreen && (r_erase_d || (spr_data != TRANSP));
  assign drawCarDone  = (r_state == ST_DRAW_DONE);
  assign eraseCarDone = (r_state == ST_ERASE_DONE);
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_x0      <= '0;
      r_y0      <= '0;
      r_valid_d <= 1'b0;
      r_erase_d <= 1'b0;
      r_col_d   <= '0;
      r_row_d   <= '0;
    end else begin
      r_valid_d <= w_issue;
      r_erase_d <= (r_state == ST_ERASE);
      r_col_d   <= w_col;
      r_row_d   <= w_row;
      case (r_state)
        ST_IDLE: begin
          if (ldXY) begin
            r_x0 <= car_x;
            r_y0 <= car_y;
          end
          if (drawCarEnable)       r_state <= ST_DRAW;
          else if (eraseCarEnable) r_state <= ST_ERASE;
        end
        ST_DRAW: begin
          if (!drawCarEnable) r_state <= ST_IDLE;
          else if (w_last)    r_state <= ST_DRAW_FLUSH;
        end
        ST_DRAW_FLUSH: r_state <= drawCarEnable ? ST_DRAW_DONE : ST_IDLE;
        ST_DRAW_DONE:  if (!drawCarEnable) r_state <= ST_IDLE;
        ST_ERASE: begin
          if (!eraseCarEnable) r_state <= ST_IDLE;
          else if (w_last)     r_state <= ST_ERASE_FLUSH;
        end
        ST_ERASE_FLUSH: r_state <= eraseCarEnable ? ST_ERASE_DONE : ST_IDLE;
        ST_ERASE_DONE:  if (!eraseCarEnable) r_state <= ST_IDLE;
        default:        r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
